ultrasonic_ranger: RTL and testbench

Parametrised HC-SR04 front end: generates the trigger pulse, times the echo in microseconds and keeps a power-of-two moving average. The averaged distance is mapped to an intensity level. It replaces the fixed 40 MHz, seven-point ranger, adding echo synchronisation, timeout detection, saturation and a valid strobe. It sits between the sensor pins and the effect-intensity consumers.

---
 rtl/ranger_pkg.sv | 24 ++
 rtl/ultrasonic_ranger_ring.sv | 40 ++++
 rtl/ultrasonic_ranger.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ranger_pkg.sv
// Shared types and width helpers for the
// ultrasonic ranger and its sample ring.
package ranger_pkg;

  typedef enum logic [1:0] {
    TRIG,
    WAIT_RISE,
    MEASURE,
    HOLDOFF
  } state_t;

  function automatic int unsigned cnt_w(
    input int unsigned n
  );
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int unsigned us_div(
    input int unsigned clk_hz
  );
    return clk_hz / 1_000_000;
  endfunction

endpackage

// File: rtl/ultrasonic_ranger_ring.sv
// DEPTH x W ring of past samples; the read
// port always shows the oldest entry.
module sample_ring #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_we,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_oldest
);

  localparam int unsigned AW =
    (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_ptr;

  assign o_oldest = r_mem[r_ptr];

  // write pointer walks the ring on every write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_we) begin
      if (r_ptr == AW'(DEPTH - 1))
        r_ptr <= '0;
      else
        r_ptr <= r_ptr + AW'(1);
    end
  end

  // storage overwrites the oldest slot
  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[r_ptr] <= i_data;
  end

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 front end: trigger, echo timing,
// moving average and intensity mapping.
module ultrasonic_ranger
  import ranger_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 40_000_000,
  parameter int unsigned TRIG_US         = 20,
  parameter int unsigned PERIOD_US       = 60000,
  parameter int unsigned MAX_US          = 3552,
  parameter int unsigned ECHO_TIMEOUT_US = 30000,
  parameter int unsigned AVG_LOG2        = 3,
  parameter int unsigned LEVELS          = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic echo,
  output logic trig,
  output logic [cnt_w(MAX_US)-1:0] dist_us,
  output logic [cnt_w(LEVELS)-1:0] intensity,
  output logic valid,
  output logic timeout
);

  localparam int unsigned W     = cnt_w(MAX_US);
  localparam int unsigned IW    = cnt_w(LEVELS);
  localparam int unsigned DIV   = us_div(CLK_HZ);
  localparam int unsigned DW    = cnt_w(DIV - 1);
  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned SW    = W + AVG_LOG2;
  localparam int unsigned FW    = cnt_w(DEPTH);
  localparam int unsigned PW    = cnt_w(PERIOD_US);
  localparam int unsigned UW    = cnt_w(
    (TRIG_US > ECHO_TIMEOUT_US) ?
    TRIG_US : ECHO_TIMEOUT_US);
  localparam int unsigned STEP  = MAX_US / LEVELS;

  logic [DW-1:0] r_div;
  logic          w_tick;
  logic [1:0]    r_sync;
  logic          r_echo_d;
  logic          w_rise;
  logic          w_fall;

  state_t        r_state;
  state_t        w_state_n;
  logic          r_trig;
  logic          w_trig_n;
  logic [UW-1:0] r_us;
  logic [PW-1:0] r_per;
  logic [W-1:0]  r_width;
  logic [W-1:0]  w_width_inc;
  logic          w_per_end;
  logic          w_us_clr;
  logic          w_us_inc;
  logic          w_per_clr;
  logic          w_width_clr;
  logic          w_commit;
  logic          w_to;
  logic [W-1:0]  w_sample;
  logic          r_commit;
  logic          r_timeout;
  logic [W-1:0]  r_sample;

  logic [SW-1:0] r_sum;
  logic [FW-1:0] r_fill;
  logic          r_commit_d;
  logic          w_full;
  logic [W-1:0]  w_oldest;
  logic [SW-1:0] w_sub;
  logic [W-1:0]  w_avg;
  logic [LEVELS:1] w_ge;
  logic [IW-1:0] w_level;

  logic [W-1:0]  r_dist;
  logic [IW-1:0] r_int;
  logic          r_valid;

  assign trig      = r_trig;
  assign dist_us   = r_dist;
  assign intensity = r_int;
  assign valid     = r_valid;
  assign timeout   = r_timeout;

  assign w_tick = (r_div == DW'(DIV - 1));

  // microsecond tick divider
  always_ff @(posedge clk) begin
    if (reset || w_tick)
      r_div <= '0;
    else
      r_div <= r_div + DW'(1);
  end

  // echo synchroniser and edge register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync   <= '0;
      r_echo_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[0], echo};
      r_echo_d <= r_sync[1];
    end
  end

  assign w_rise = r_sync[1] & ~r_echo_d;
  assign w_fall = ~r_sync[1] & r_echo_d;

  assign w_per_end = w_tick &&
    (r_per == PW'(PERIOD_US - 1));

  assign w_width_inc =
    (w_tick && r_width != W'(MAX_US)) ?
    r_width + W'(1) : r_width;

  // next state, trigger and commit decisions
  always_comb begin
    w_state_n   = r_state;
    w_trig_n    = r_trig;
    w_us_clr    = 1'b0;
    w_us_inc    = 1'b0;
    w_per_clr   = 1'b0;
    w_width_clr = 1'b0;
    w_commit    = 1'b0;
    w_to        = 1'b0;
    w_sample    = W'(MAX_US);
    unique case (r_state)
      TRIG: begin
        if (w_tick) begin
          if (!r_trig) begin
            w_trig_n  = 1'b1;
            w_us_clr  = 1'b1;
            w_per_clr = 1'b1;
          end else if (r_us == UW'(TRIG_US - 1)) begin
            w_trig_n  = 1'b0;
            w_us_clr  = 1'b1;
            w_state_n = WAIT_RISE;
          end else begin
            w_us_inc  = 1'b1;
          end
        end
      end
      WAIT_RISE: begin
        if (w_per_end) begin
          w_commit  = 1'b1;
          w_to      = 1'b1;
          w_state_n = TRIG;
          w_trig_n  = 1'b1;
          w_us_clr  = 1'b1;
          w_per_clr = 1'b1;
        end else if (w_rise) begin
          w_width_clr = 1'b1;
          w_state_n   = MEASURE;
        end else if (w_tick) begin
          if (r_us == UW'(ECHO_TIMEOUT_US - 1)) begin
            w_commit  = 1'b1;
            w_to      = 1'b1;
            w_state_n = HOLDOFF;
          end else begin
            w_us_inc  = 1'b1;
          end
        end
      end
      MEASURE: begin
        if (w_per_end) begin
          w_commit  = 1'b1;
          w_to      = 1'b1;
          w_state_n = TRIG;
          w_trig_n  = 1'b1;
          w_us_clr  = 1'b1;
          w_per_clr = 1'b1;
        end else if (w_fall) begin
          w_commit  = 1'b1;
          w_sample  = w_width_inc;
          w_state_n = HOLDOFF;
        end
      end
      HOLDOFF: begin
        if (w_per_end) begin
          w_state_n = TRIG;
          w_trig_n  = 1'b1;
          w_us_clr  = 1'b1;
          w_per_clr = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // state register and measurement counters
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= TRIG;
      r_trig    <= 1'b0;
      r_us      <= '0;
      r_per     <= '0;
      r_width   <= '0;
      r_commit  <= 1'b0;
      r_timeout <= 1'b0;
      r_sample  <= '0;
    end else begin
      r_state   <= w_state_n;
      r_trig    <= w_trig_n;
      r_commit  <= w_commit;
      r_timeout <= w_to;
      r_sample  <= w_sample;
      if (w_us_clr)
        r_us <= '0;
      else if (w_us_inc)
        r_us <= r_us + UW'(1);
      if (w_per_clr)
        r_per <= '0;
      else if (w_tick)
        r_per <= r_per + PW'(1);
      if (w_width_clr)
        r_width <= '0;
      else if (r_state == MEASURE)
        r_width <= w_width_inc;
    end
  end

  sample_ring #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .i_we     (r_commit),
    .i_data   (r_sample),
    .o_oldest (w_oldest)
  );

  assign w_full = (r_fill == FW'(DEPTH));
  assign w_sub  = w_full ?
    SW'(w_oldest) : SW'(MAX_US);
  assign w_avg  = r_sum[SW-1:AVG_LOG2];

  // running sum, prefilled with far samples
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum      <= SW'(DEPTH * MAX_US);
      r_fill     <= '0;
      r_commit_d <= 1'b0;
    end else begin
      r_commit_d <= r_commit;
      if (r_commit) begin
        r_sum <= r_sum - w_sub + SW'(r_sample);
        if (!w_full)
          r_fill <= r_fill + FW'(1);
      end
    end
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_cmp
    assign w_ge[k] = (w_avg >= W'(k * STEP));
  end

  // level drops by one per step passed
  always_comb begin
    w_level = IW'(LEVELS);
    for (int k = 1; k < LEVELS; k++) begin
      if (w_ge[k])
        w_level = w_level - IW'(1);
    end
    if (w_ge[LEVELS])
      w_level = '0;
  end

  // registered outputs with valid strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dist  <= W'(MAX_US);
      r_int   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_commit_d;
      if (r_commit_d) begin
        r_dist <= w_avg;
        r_int  <= w_level;
      end
    end
  end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Directed bench for ultrasonic_ranger at
// 4 MHz, 200 us period, 4-deep average.
module tb_ultrasonic_ranger;

  logic       clk = 1'b0;
  logic       reset;
  logic       echo;
  logic       trig;
  logic [7:0] dist_us;
  logic [3:0] intensity;
  logic       valid;
  logic       timeout;

  int tests = 0;
  int fails = 0;
  int vcnt  = 0;
  int tcnt  = 0;

  always #5 clk = ~clk;

  ultrasonic_ranger #(
    .CLK_HZ          (4_000_000),
    .TRIG_US         (20),
    .PERIOD_US       (200),
    .MAX_US          (160),
    .ECHO_TIMEOUT_US (100),
    .AVG_LOG2        (2),
    .LEVELS          (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .echo      (echo),
    .trig      (trig),
    .dist_us   (dist_us),
    .intensity (intensity),
    .valid     (valid),
    .timeout   (timeout)
  );

  always @(negedge clk) begin
    if (valid === 1'b1)
      vcnt <= vcnt + 1;
    if (timeout === 1'b1)
      tcnt <= tcnt + 1;
  end

  task automatic wait_trig(
    input logic  lvl,
    input string what
  );
    int n = 0;
    while (trig !== lvl && n < 2000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (trig !== lvl) begin
      fails++;
      $display("FAIL %s: trig=%b want %b",
               what, trig, lvl);
    end
  endtask

  task automatic period(
    input int dly_us,
    input int hi_us
  );
    wait_trig(1'b1, "period_rise");
    wait_trig(1'b0, "period_fall");
    repeat (dly_us * 4) @(negedge clk);
    echo = 1'b1;
    repeat (hi_us * 4) @(negedge clk);
    echo = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    echo  = 1'b0;
    repeat (5) @(negedge clk);
    tests++;
    if (trig !== 1'b0 || dist_us !== 8'd160 ||
        intensity !== 4'd0 || valid !== 1'b0 ||
        timeout !== 1'b0) begin
      fails++;
      $display("FAIL reset_vals: t=%b d=%0d i=%0d v=%b to=%b",
               trig, dist_us, intensity, valid, timeout);
    end
    reset = 1'b0;
    n = 0;
    while (trig !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL first_trig: %0d cycles want 4", n);
    end
    n = 0;
    while (trig === 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 80) begin
      fails++;
      $display("FAIL trig_width: %0d cycles want 80", n);
    end
    tests++;
    if (vcnt != 0 || dist_us !== 8'd160) begin
      fails++;
      $display("FAIL pre_commit: valids=%0d d=%0d want 0,160",
               vcnt, dist_us);
    end
  endtask

  task automatic test_echo40();
    logic [7:0] exp_d [4];
    logic [3:0] exp_i [4];
    int v0;
    exp_d[0] = 8'd130; exp_i[0] = 4'd2;
    exp_d[1] = 8'd100; exp_i[1] = 4'd3;
    exp_d[2] = 8'd70;  exp_i[2] = 4'd5;
    exp_d[3] = 8'd40;  exp_i[3] = 4'd6;
    for (int p = 0; p < 4; p++) begin
      v0 = vcnt;
      if (p == 0) begin
        repeat (20) @(negedge clk);
        echo = 1'b1;
        repeat (160) @(negedge clk);
        echo = 1'b0;
        repeat (8) @(negedge clk);
      end else begin
        period(5, 40);
      end
      tests++;
      if (dist_us !== exp_d[p]) begin
        fails++;
        $display("FAIL echo40_dist[%0d]: %0d want %0d",
                 p, dist_us, exp_d[p]);
      end
      tests++;
      if (intensity !== exp_i[p]) begin
        fails++;
        $display("FAIL echo40_int[%0d]: %0d want %0d",
                 p, intensity, exp_i[p]);
      end
      tests++;
      if (vcnt - v0 != 1) begin
        fails++;
        $display("FAIL echo40_valid[%0d]: %0d want 1",
                 p, vcnt - v0);
      end
    end
  endtask

  task automatic test_timeout(input logic pre);
    int n;
    int v0;
    int t0;
    v0 = vcnt;
    t0 = tcnt;
    if (pre)
      echo = 1'b1;
    wait_trig(1'b1, "to_rise");
    wait_trig(1'b0, "to_fall");
    n = 0;
    while (timeout !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 400) begin
      fails++;
      $display("FAIL to_delay(pre=%b): %0d cycles want 400",
               pre, n);
    end
    echo = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if (pre == 1'b0 &&
        (dist_us !== 8'd70 || intensity !== 4'd5)) begin
      fails++;
      $display("FAIL to_none_out: d=%0d i=%0d want 70,5",
               dist_us, intensity);
    end
    if (pre == 1'b1 &&
        (dist_us !== 8'd100 || intensity !== 4'd3)) begin
      fails++;
      $display("FAIL to_pre_out: d=%0d i=%0d want 100,3",
               dist_us, intensity);
    end
    tests++;
    if (vcnt - v0 != 1 || tcnt - t0 != 1) begin
      fails++;
      $display("FAIL to_pulses(pre=%b): v=%0d t=%0d want 1,1",
               pre, vcnt - v0, tcnt - t0);
    end
  endtask

  task automatic test_saturate();
    int v0;
    int t0;
    v0 = vcnt;
    t0 = tcnt;
    period(5, 300);
    tests++;
    if (dist_us !== 8'd160 || intensity !== 4'd0) begin
      fails++;
      $display("FAIL sat300_out: d=%0d i=%0d want 160,0",
               dist_us, intensity);
    end
    tests++;
    if (vcnt - v0 != 2 || tcnt - t0 != 2) begin
      fails++;
      $display("FAIL sat300_pulses: v=%0d t=%0d want 2,2",
               vcnt - v0, tcnt - t0);
    end
    v0 = vcnt;
    t0 = tcnt;
    for (int p = 0; p < 2; p++) begin
      period(5, 170);
      tests++;
      if (dist_us !== 8'd160 || intensity !== 4'd0) begin
        fails++;
        $display("FAIL sat170_out[%0d]: d=%0d i=%0d want 160,0",
                 p, dist_us, intensity);
      end
    end
    tests++;
    if (vcnt - v0 != 2 || tcnt - t0 != 0) begin
      fails++;
      $display("FAIL sat170_pulses: v=%0d t=%0d want 2,0",
               vcnt - v0, tcnt - t0);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    int v0;
    period(5, 40);
    tests++;
    if (dist_us !== 8'd130 || intensity !== 4'd2) begin
      fails++;
      $display("FAIL mid_pre: d=%0d i=%0d want 130,2",
               dist_us, intensity);
    end
    wait_trig(1'b1, "mid_rise");
    wait_trig(1'b0, "mid_fall");
    repeat (20) @(negedge clk);
    echo = 1'b1;
    repeat (80) @(negedge clk);
    v0 = vcnt;
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (trig !== 1'b0 || dist_us !== 8'd160 ||
        intensity !== 4'd0 || valid !== 1'b0 ||
        timeout !== 1'b0) begin
      fails++;
      $display("FAIL mid_reset_vals: t=%b d=%0d i=%0d v=%b to=%b",
               trig, dist_us, intensity, valid, timeout);
    end
    reset = 1'b0;
    echo  = 1'b0;
    n = 0;
    while (trig !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL mid_first_trig: %0d cycles want 4", n);
    end
    repeat (400) @(negedge clk);
    tests++;
    if (vcnt != v0 || dist_us !== 8'd160) begin
      fails++;
      $display("FAIL mid_no_valid: v=%0d d=%0d want 0,160",
               vcnt - v0, dist_us);
    end
  endtask

  initial begin
    test_reset();
    test_echo40();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
